// File: rtl/hex_digit_formatter_pkg.sv
// Shared types and constants for hex_digit_formatter.
// Optional decimal mode is enabled by defining HEX_FMT_DECIMAL_EN.
package hex_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_DIGITS = 6;

    // Largest value representable in n decimal digits (10^n - 1); n <= 8 fits 32 bits.
    function automatic logic [31:0] dec_limit(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/hex_digit_formatter_bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_add3 (
    input  logic [3:0] raw,
    output logic [3:0] adjusted
);

    assign adjusted = (raw >= 4'd5) ? (raw + 4'd3) : raw;

endmodule

// File: rtl/hex_digit_formatter.sv
// Formats a binary value as hex or BCD digits with leading-zero blanking.
// Decimal mode (CONVERT state, BCD datapath, overflow) exists only with HEX_FMT_DECIMAL_EN.
module hex_digit_formatter
    import hex_fmt_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
    input  logic                    clk_ref,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic                    in_dec,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    out_valid,
    output logic                    overflow
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~(NUM_DIGITS'(1));

    // Handshake: a value transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state and reset, never on in_valid.
    state_t state;

    assign in_ready = (state == IDLE) && !reset;

    // A digit is blank when it and every more significant digit are zero; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] blank_of(input logic [VW-1:0] v);
        logic                  seen;
        logic [NUM_DIGITS-1:0] res;
        seen = 1'b0;
        res  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] != 4'h0) seen = 1'b1;
            res[i] = !seen && (i != 0);
        end
        return res;
    endfunction

`ifdef HEX_FMT_DECIMAL_EN
    localparam logic [VW-1:0] DEC_MAX   = VW'(dec_limit(NUM_DIGITS));
    localparam logic [VW-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [5:0]    LAST_STEP = 6'(4 * NUM_DIGITS - 1);

    logic [VW-1:0] shift_reg;
    logic [VW-1:0] bcd;
    logic [VW-1:0] bcd_adj;
    logic [VW-1:0] bcd_step;
    logic [5:0]    count;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .raw      (bcd[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Correct every nibble, then shift in the next input bit MSB-first.
    assign bcd_step = {bcd_adj[VW-2:0], shift_reg[VW-1]};
`else
    logic unused_dec;
    assign unused_dec = in_dec;
`endif

    always_ff @(posedge clk_ref) begin
        if (reset) begin
            state       <= IDLE;
            digits      <= '0;
            digit_blank <= BLANK_RST;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
`ifdef HEX_FMT_DECIMAL_EN
            shift_reg   <= '0;
            bcd         <= '0;
            count       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef HEX_FMT_DECIMAL_EN
                        if (in_dec && (in_value <= DEC_MAX)) begin
                            state     <= CONVERT;
                            shift_reg <= in_value;
                            bcd       <= '0;
                            count     <= '0;
                        end else if (in_dec) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            digits      <= ALL_NINES;
                            digit_blank <= '0;
                            overflow    <= 1'b1;
                        end else begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            digits      <= in_value;
                            digit_blank <= blank_of(in_value);
                            overflow    <= 1'b0;
                        end
`else
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        digits      <= in_value;
                        digit_blank <= blank_of(in_value);
                        overflow    <= 1'b0;
`endif
                    end
                end
`ifdef HEX_FMT_DECIMAL_EN
                CONVERT: begin
                    shift_reg <= shift_reg << 1;
                    bcd       <= bcd_step;
                    count     <= count + 6'd1;
                    // The final step publishes straight to the outputs, saving a cycle.
                    if (count == LAST_STEP) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        digits      <= bcd_step;
                        digit_blank <= blank_of(bcd_step);
                        overflow    <= 1'b0;
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
